// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding and
// default frame parameters.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_STOP_BITS    = 1;
  localparam int UART_CLKS_PER_BIT = 16;

endpackage

// File: rtl/uart_transmitter.sv
// UART serializer: accepts one word per valid/ready handshake and shifts it
// out as start bit, LSB-first data bits and stop bits, each CLKS_PER_BIT clocks.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = UART_DATA_BITS,
  parameter int STOP_BITS    = UART_STOP_BITS,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx,
  output logic                 ready_out
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [1:0]       STOP_LAST = 2'(STOP_BITS - 1);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_transmitter: DATA_BITS must be in 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_transmitter: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_transmitter: CLKS_PER_BIT must be at least 2");
    end
  endgenerate

  uart_state_t          state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [BIT_W-1:0]     bit_reg, bit_next;
  logic [1:0]           stop_reg, stop_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 tx_reg, tx_next;

  logic period_done;
  assign period_done = (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      stop_reg  <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      stop_reg  <= stop_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    stop_next  = stop_reg;
    shift_next = shift_reg;

    case (state_reg)
      IDLE: begin
        if (valid_in) begin
          state_next = START;
          shift_next = data_in;
          cnt_next   = '0;
          bit_next   = '0;
          stop_next  = '0;
        end
      end
      START: begin
        if (period_done) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DATA: begin
        if (period_done) begin
          cnt_next   = '0;
          shift_next = shift_reg >> 1;
          bit_next   = bit_reg + 1'b1;
          if (bit_reg == BIT_LAST) begin
            stop_next  = '0;
            state_next = STOP;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      STOP: begin
        if (period_done) begin
          cnt_next = '0;
          if (stop_reg == STOP_LAST) begin
            stop_next  = '0;
            state_next = IDLE;
          end else begin
            stop_next = stop_reg + 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level is computed from the upcoming state so tx leaves a flop.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  assign tx        = tx_reg;
  assign ready_out = (state_reg == IDLE);

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench: a default-parameter instance and a STOP_BITS=2,
// CLKS_PER_BIT=4 instance, each compared every cycle with a frame model.
module tb_uart_transmitter;

  localparam int DB = 8;
  localparam int CA = 16;
  localparam int SA = 1;
  localparam int LA = (1 + DB + SA) * CA;
  localparam int CB = 4;
  localparam int SB = 2;
  localparam int LB = (1 + DB + SB) * CB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_a = 1'b0;
  logic          valid_b = 1'b0;
  logic [DB-1:0] data_a = '0;
  logic [DB-1:0] data_b = '0;
  logic          tx_a, ready_a, tx_b, ready_b;

  always #5 clk = ~clk;

  uart_transmitter #(.DATA_BITS(DB), .STOP_BITS(SA), .CLKS_PER_BIT(CA)) dut_a (
    .clk(clk), .rst(rst), .valid_in(valid_a), .data_in(data_a),
    .tx(tx_a), .ready_out(ready_a)
  );

  uart_transmitter #(.DATA_BITS(DB), .STOP_BITS(SB), .CLKS_PER_BIT(CB)) dut_b (
    .clk(clk), .rst(rst), .valid_in(valid_b), .data_in(data_b),
    .tx(tx_b), .ready_out(ready_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Line level at a given clock offset into a frame: start, data LSB first, stop.
  function automatic logic frame_bit(input logic [DB-1:0] d, input int cpb, input int off);
    int idx;
    idx = off / cpb;
    if (idx == 0)       return 1'b0;
    else if (idx <= DB) return d[idx-1];
    else                return 1'b1;
  endfunction

  // Reference model: a frame occupies a fixed number of clocks after acceptance.
  int            cyc = 0;
  bit            ma_act = 1'b0, mb_act = 1'b0;
  int            ma_off = 0, mb_off = 0;
  logic [DB-1:0] ma_data = '0, mb_data = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      ma_act <= 1'b0;
      mb_act <= 1'b0;
    end else begin
      if (ma_act) begin
        if (ma_off + 1 == LA) ma_act <= 1'b0;
        ma_off <= ma_off + 1;
      end else if (valid_a) begin
        ma_act  <= 1'b1;
        ma_off  <= 0;
        ma_data <= data_a;
      end
      if (mb_act) begin
        if (mb_off + 1 == LB) mb_act <= 1'b0;
        mb_off <= mb_off + 1;
      end else if (valid_b) begin
        mb_act  <= 1'b1;
        mb_off  <= 0;
        mb_data <= data_b;
      end
    end
  end

  bit chk_en = 1'b0;
  bit prev_ready_a = 1'b1;
  int frames_a = 0;
  int fall_q[$];

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("tx_a", 32'(tx_a), 32'(ma_act ? frame_bit(ma_data, CA, ma_off) : 1'b1));
      check("ready_a", 32'(ready_a), 32'(!ma_act));
      check("tx_b", 32'(tx_b), 32'(mb_act ? frame_bit(mb_data, CB, mb_off) : 1'b1));
      check("ready_b", 32'(ready_b), 32'(!mb_act));
    end
    if (prev_ready_a && !ready_a) begin
      frames_a <= frames_a + 1;
      fall_q.push_back(cyc);
    end
    prev_ready_a <= ready_a;
  end

  // Sends one word and measures the frame from the DUT side.
  task automatic send(input bit sel, input logic [DB-1:0] d, input bit toggle, input bit pulse,
                      output logic [15:0] mids, output int busy, output int low_cnt,
                      output int stop_hi);
    int cpb, len, w, n;
    logic txv, rdy;
    cpb = sel ? CB : CA;
    len = sel ? LB : LA;
    mids = '0; busy = 0; low_cnt = 0; stop_hi = 0;
    w = 0;
    while (!(sel ? ready_b : ready_a) && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (w >= 500) check("ready_wait", 0, 1);
    if (sel) begin valid_b = 1'b1; data_b = d; end
    else     begin valid_a = 1'b1; data_a = d; end
    @(negedge clk);
    valid_a = 1'b0;
    valid_b = 1'b0;
    n = 1;
    while (n <= 2 * len) begin
      txv = sel ? tx_b : tx_a;
      rdy = sel ? ready_b : ready_a;
      if (rdy) break;
      busy++;
      if (!txv) low_cnt++;
      if (n > (1 + DB) * cpb && txv) stop_hi++;
      if ((n - 1) % cpb == cpb / 2) mids[(n - 1) / cpb] = txv;
      if (toggle) begin
        if (sel) data_b = 8'($urandom);
        else     data_a = 8'($urandom);
      end
      if (pulse && n > 2 && n < len - 2) begin
        if (sel) valid_b = 1'($urandom);
        else     valid_a = 1'($urandom);
      end else begin
        valid_a = 1'b0;
        valid_b = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    valid_a = 1'b0;
    valid_b = 1'b0;
    if (n > 2 * len) check("frame_timeout", 0, 1);
    $display("frame dut=%s data=%02h mids=%03h busy=%0d low=%0d stop_hi=%0d",
             sel ? "b" : "a", d, mids, busy, low_cnt, stop_hi);
  endtask

  logic [15:0] mids;
  int busy, low_cnt, stop_hi, f0, w;
  logic [DB-1:0] d;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx_a", 32'(tx_a), 1);
    check("rst_ready_a", 32'(ready_a), 1);
    check("rst_tx_b", 32'(tx_b), 1);
    check("rst_ready_b", 32'(ready_b), 1);
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);

    send(1'b0, 8'h55, 1'b0, 1'b0, mids, busy, low_cnt, stop_hi);
    check("mids_55", 32'(mids), 32'h2AA);
    check("busy_55", busy, 160);

    send(1'b0, 8'hA3, 1'b1, 1'b0, mids, busy, low_cnt, stop_hi);
    check("mids_a3", 32'(mids), 32'h346);
    check("busy_a3", busy, 160);

    send(1'b0, 8'hFF, 1'b0, 1'b0, mids, busy, low_cnt, stop_hi);
    check("mids_ff", 32'(mids), 32'h3FE);
    check("low_ff", low_cnt, CA);

    send(1'b1, 8'h3C, 1'b0, 1'b0, mids, busy, low_cnt, stop_hi);
    check("mids_3c", 32'(mids), 32'h678);
    check("busy_3c", busy, 44);
    check("stop_3c", stop_hi, 8);
    check("low_3c", low_cnt, 20);

    // Continuous valid: frames must abut with a single idle clock between.
    fall_q.delete();
    valid_a = 1'b1;
    w = 0;
    while (fall_q.size() < 4 && w < 4 * (LA + 1) + 50) begin
      data_a = (frames_a % 2 == 0) ? 8'h5A : 8'hA5;
      @(negedge clk);
      w++;
    end
    valid_a = 1'b0;
    check("b2b_count", fall_q.size(), 4);
    for (int i = 1; i < fall_q.size(); i++) begin
      check("b2b_period", fall_q[i] - fall_q[i-1], LA + 1);
      $display("b2b frame %0d starts %0d clocks after previous", i, fall_q[i] - fall_q[i-1]);
    end
    repeat (LA + 4) @(negedge clk);

    // Random words with valid pulses while busy; exactly one frame per send.
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      f0 = frames_a;
      send(1'b0, d, 1'b1, 1'b1, mids, busy, low_cnt, stop_hi);
      repeat (3) @(negedge clk);
      check("rand_mids_a", 32'(mids), 32'({1'b1, d, 1'b0}));
      check("rand_busy_a", busy, LA);
      check("rand_frames_a", frames_a - f0, 1);
      d = 8'($urandom);
      send(1'b1, d, 1'b1, 1'b1, mids, busy, low_cnt, stop_hi);
      check("rand_mids_b", 32'(mids), 32'({2'b11, d, 1'b0}));
      check("rand_busy_b", busy, LB);
      check("rand_stop_b", stop_hi, SB * CB);
    end

    // Asynchronous reset in the middle of a zero-data frame.
    repeat (2) @(negedge clk);
    valid_a = 1'b1;
    data_a  = 8'h00;
    @(negedge clk);
    valid_a = 1'b0;
    repeat (40) @(negedge clk);
    chk_en = 1'b0;
    check("pre_rst_tx_a", 32'(tx_a), 0);
    check("pre_rst_ready_a", 32'(ready_a), 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_tx_a", 32'(tx_a), 1);
    check("async_rst_ready_a", 32'(ready_a), 1);
    $display("async reset mid-frame: tx_a=%0b ready_a=%0b", tx_a, ready_a);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    send(1'b0, 8'hC6, 1'b0, 1'b0, mids, busy, low_cnt, stop_hi);
    check("post_rst_mids", 32'(mids), 32'h38C);
    check("post_rst_busy", busy, LA);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
